uart_tx_scheduler: RTL and testbench

- Shares one UART transmitter (the serializer paced by baud_rate_gen) between NUM_REQ byte-stream requesters, e.g. the CPU Avalon slave path and a debug/trace source.
- Uses round-robin arbitration with burst locking: a granted requester keeps the transmitter until it flags the last byte, hits MAX_BURST bytes, or stalls longer than HOLD_CYCLES.
- Sequences the transmitter with a one-cycle start pulse and waits for its frame-done pulse. Exposes a 3-bit state for bench and debug display.

---
 rtl/uart_sched_pkg.sv | 28 ++
 rtl/uart_tx_scheduler_rr_pick.sv | 34 +++
 rtl/uart_tx_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler.
//    sched_state_t  : FSM state names with their fixed 3-bit encodings
//    ST_*           : the same encodings as plain logic constants, so the FSM
//                     register can also hold (and recover from) codes 5..7
//    DATA_W_DEF     : default byte width per UART frame
//    BYTE_CNT_W     : width of the free-running byte counter
//    GRANT_ID_W     : width of the grant index (covers up to 8 requesters)
package uart_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GRANT   = 3'd1,
      S_START   = 3'd2,
      S_WAIT    = 3'd3,
      S_RELEASE = 3'd4
   } sched_state_t;

   localparam logic [2:0] ST_IDLE    = 3'(S_IDLE);
   localparam logic [2:0] ST_GRANT   = 3'(S_GRANT);
   localparam logic [2:0] ST_START   = 3'(S_START);
   localparam logic [2:0] ST_WAIT    = 3'(S_WAIT);
   localparam logic [2:0] ST_RELEASE = 3'(S_RELEASE);

   localparam int DATA_W_DEF = 8;
   localparam int BYTE_CNT_W = 16;
   localparam int GRANT_ID_W = 3;

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Round-robin picker.
// Scans the request vector starting one position after the previous owner
// and wrapping, so the previous owner is always considered last.
// Ports:
//    i_req    : request vector, one bit per requester
//    i_last   : index of the requester that most recently released
//    o_found  : at least one request bit is set
//    o_index  : winning requester (0 when nothing is requested)
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 3
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic               o_found,
   output logic [IDX_W-1:0]   o_index
);

   // Outer loop walks priority order (offset 1 = highest); the inner loop
   // turns that offset into a constant bit position so every index stays static.
   always_comb begin
      o_found = 1'b0;
      o_index = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_found && i_req[k] && (((int'(i_last) + off) % NUM_REQ) == k)) begin
               o_found = 1'b1;
               o_index = IDX_W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART serializer between NUM_REQ byte-stream requesters.
// A requester, once granted, keeps the transmitter until it flags its last
// byte, sends MAX_BURST bytes, or leaves valid low for HOLD_CYCLES cycles.
// Each byte is handed over with a one-cycle start pulse and the scheduler
// then waits for the serializer's frame-done pulse.
// Ports:
//    clock, resetn : system clock, asynchronous active-low reset
//    req_valid     : per-requester byte valid
//    req_data      : per-requester byte, requester i at [i*DATA_W +: DATA_W]
//    req_last      : per-requester end-of-burst marker
//    req_ready     : one-hot byte accept (combinational)
//    tx_start      : one-cycle start pulse to the serializer
//    tx_data       : byte being sent, stable from tx_start until tx_done
//    tx_done       : end-of-stop-bit pulse from the serializer
//    grant_valid   : a requester currently owns the transmitter
//    grant_id      : owning requester (kept after release for debug)
//    byte_count    : bytes started since reset, wrapping
//    state         : current FSM state code
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no owner; pick next requester round-robin
// S_GRANT   | owner selected; accept its next byte or count idle cycles
// S_START   | tx_start is high for this single cycle
// S_WAIT    | serializer busy; wait for tx_done
// S_RELEASE | drop ownership, remember owner as lowest priority
// 5..7      | illegal; recover to S_IDLE
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int MAX_BURST   = 16,
   parameter int HOLD_CYCLES = 16
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_start,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_done,
   output logic                      grant_valid,
   output logic [GRANT_ID_W-1:0]     grant_id,
   output logic [BYTE_CNT_W-1:0]     byte_count,
   output logic [2:0]                state
);

   logic [2:0]            r_state;
   logic                  r_tx_start;
   logic [DATA_W-1:0]     r_tx_data;
   logic                  r_grant_valid;
   logic [GRANT_ID_W-1:0] r_grant_id;
   logic [GRANT_ID_W-1:0] r_last_grant;
   logic [BYTE_CNT_W-1:0] r_byte_count;
   logic [7:0]            r_burst_cnt;
   logic [7:0]            r_hold_cnt;
   logic                  r_last_flag;

   logic                  w_found;
   logic [GRANT_ID_W-1:0] w_pick;
   logic                  w_sel_valid;
   logic                  w_sel_last;
   logic [DATA_W-1:0]     w_sel_data;
   logic                  w_accept;
   logic                  w_burst_full;
   logic                  w_hold_expired;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (GRANT_ID_W)
   ) u_rr_pick (
      .i_req   (req_valid),
      .i_last  (r_last_grant),
      .o_found (w_found),
      .o_index (w_pick)
   );

   // Select the owner's lane with a compare per lane rather than a variable
   // bit-select, since grant_id is wider than log2(NUM_REQ).
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_data  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (r_grant_id == GRANT_ID_W'(k)) begin
            w_sel_valid = req_valid[k];
            w_sel_last  = req_last[k];
            w_sel_data  = req_data[k*DATA_W +: DATA_W];
         end
      end
   end

   assign w_accept       = (r_state == ST_GRANT) && w_sel_valid;
   assign w_burst_full   = (r_burst_cnt == 8'(MAX_BURST));
   assign w_hold_expired = (r_hold_cnt == 8'(HOLD_CYCLES - 1));

   always_comb begin
      req_ready = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         req_ready[k] = w_accept && (r_grant_id == GRANT_ID_W'(k));
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state       <= ST_IDLE;
         r_tx_start    <= 1'b0;
         r_tx_data     <= '0;
         r_grant_valid <= 1'b0;
         r_grant_id    <= '0;
         r_last_grant  <= GRANT_ID_W'(NUM_REQ - 1);
         r_byte_count  <= '0;
         r_burst_cnt   <= '0;
         r_hold_cnt    <= '0;
         r_last_flag   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_grant_id    <= w_pick;
                  r_grant_valid <= 1'b1;
                  r_burst_cnt   <= '0;
                  r_hold_cnt    <= '0;
                  r_state       <= ST_GRANT;
               end
            end

            ST_GRANT: begin
               if (w_sel_valid) begin
                  r_tx_data    <= w_sel_data;
                  r_last_flag  <= w_sel_last;
                  r_burst_cnt  <= r_burst_cnt + 8'd1;
                  r_byte_count <= r_byte_count + BYTE_CNT_W'(1);
                  r_tx_start   <= 1'b1;
                  r_state      <= ST_START;
               end else if (w_hold_expired) begin
                  r_state <= ST_RELEASE;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 8'd1;
               end
            end

            ST_START: begin
               r_tx_start <= 1'b0;
               r_state    <= ST_WAIT;
            end

            ST_WAIT: begin
               if (tx_done) begin
                  r_hold_cnt <= '0;
                  if (r_last_flag || w_burst_full) begin
                     r_state <= ST_RELEASE;
                  end else begin
                     r_state <= ST_GRANT;
                  end
               end
            end

            ST_RELEASE: begin
               // The releasing owner becomes lowest priority for the next pick.
               r_last_grant  <= r_grant_id;
               r_grant_valid <= 1'b0;
               r_state       <= ST_IDLE;
            end

            default: begin
               r_tx_start    <= 1'b0;
               r_grant_valid <= 1'b0;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_start    = r_tx_start;
   assign tx_data     = r_tx_data;
   assign grant_valid = r_grant_valid;
   assign grant_id    = r_grant_id;
   assign byte_count  = r_byte_count;
   assign state       = r_state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

   localparam int NR    = 3;
   localparam int DW    = 8;
   localparam int MB    = 4;
   localparam int HC    = 16;
   localparam int TXLAT = 12;

   localparam logic [2:0] E_IDLE  = 3'd0;
   localparam logic [2:0] E_GRANT = 3'd1;
   localparam logic [2:0] E_START = 3'd2;
   localparam logic [2:0] E_WAIT  = 3'd3;
   localparam logic [2:0] E_REL   = 3'd4;

   logic              clock     = 1'b0;
   logic              resetn    = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*DW-1:0]  req_data  = '0;
   logic [NR-1:0]     req_last  = '0;
   logic [NR-1:0]     req_ready;
   logic              tx_start;
   logic [DW-1:0]     tx_data;
   logic              tx_done   = 1'b0;
   logic              grant_valid;
   logic [2:0]        grant_id;
   logic [15:0]       byte_count;
   logic [2:0]        state;

   uart_tx_scheduler #(
      .NUM_REQ     (NR),
      .DATA_W      (DW),
      .MAX_BURST   (MB),
      .HOLD_CYCLES (HC)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .byte_count  (byte_count),
      .state       (state)
   );

   initial forever #5 clock = ~clock;

   typedef struct packed { logic [7:0] d; logic l; } ent_t;
   typedef struct packed { logic [2:0] id; logic [7:0] d; } tx_t;

   ent_t  rq [NR][64];
   int    rhead [NR];
   int    rtail [NR];
   tx_t   exp_q [$];
   tx_t   mon_q [$];
   int    m_last = NR - 1;
   logic [15:0] m_bc = '0;
   int    tx_cnt = 0;
   bit    inject = 1'b0;
   logic  prev_start = 1'b0;
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic push_req(int r, logic [7:0] d, logic l);
      rq[r][rtail[r]] = {d, l};
      rtail[r]++;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NR; i++) begin
         rhead[i] = 0;
         rtail[i] = 0;
      end
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NR; i++) if (rhead[i] != rtail[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive_reqs();
      for (int i = 0; i < NR; i++) begin
         if (rhead[i] < rtail[i]) begin
            req_valid[i]            = 1'b1;
            req_data[i*DW +: DW]    = rq[i][rhead[i]].d;
            req_last[i]             = rq[i][rhead[i]].l;
         end else begin
            req_valid[i]            = 1'b0;
            req_data[i*DW +: DW]    = '0;
            req_last[i]             = 1'b0;
         end
      end
   endtask

   // Transaction-level reference: all queued bytes are presented at once, so
   // the grant order follows from round-robin over non-empty queues, each
   // burst ending on a last flag, MAX_BURST bytes, or an emptied queue.
   task automatic predict();
      int h [NR];
      int p, n;
      bit stop;
      for (int i = 0; i < NR; i++) h[i] = rhead[i];
      forever begin
         p = -1;
         for (int off = 1; off <= NR; off++) begin
            int c;
            c = (m_last + off) % NR;
            if (p < 0 && h[c] < rtail[c]) p = c;
         end
         if (p < 0) break;
         n = 0;
         stop = 1'b0;
         while (!stop && h[p] < rtail[p]) begin
            exp_q.push_back({3'(p), rq[p][h[p]].d});
            m_bc++;
            n++;
            stop = rq[p][h[p]].l || (n == MB);
            h[p]++;
         end
         m_last = p;
      end
   endtask

   task automatic clear_tb();
      clear_reqs();
      mon_q.delete();
      exp_q.delete();
      m_last = NR - 1;
      m_bc   = '0;
      inject = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      #2 resetn = 1'b0;
      clear_tb();
      repeat (2) @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic wait_done(int budget, output bit ok);
      int c;
      c  = 0;
      ok = 1'b1;
      while (!(mon_q.size() >= exp_q.size() && state == E_IDLE && all_empty())) begin
         @(negedge clock);
         c++;
         if (c > budget) begin
            ok = 1'b0;
            return;
         end
      end
   endtask

   // Requester driver: a byte leaves its queue after the edge at which ready was high.
   initial begin : drv
      logic [NR-1:0] acc;
      forever begin
         @(negedge clock);
         acc = req_ready;
         @(posedge clock);
         #1;
         for (int i = 0; i < NR; i++) if (acc[i] && rhead[i] < rtail[i]) rhead[i]++;
         drive_reqs();
      end
   end

   // Serializer model (tx_done TXLAT cycles after tx_start) and start-pulse monitor.
   initial begin : txm
      forever begin
         @(posedge clock);
         #1;
         tx_done = 1'b0;
         if (!resetn) begin
            tx_cnt = 0;
         end else begin
            if (tx_cnt > 0) begin
               tx_cnt--;
               if (tx_cnt == 0) tx_done = 1'b1;
            end
            if (inject) begin
               tx_done = 1'b1;
               inject  = 1'b0;
            end
            if (tx_start) begin
               n_cmp++;
               if (prev_start) begin
                  n_bad++;
                  $display("FAIL start_width: tx_start high for 2+ cycles, required 1");
               end
               n_cmp++;
               if (grant_valid !== 1'b1) begin
                  n_bad++;
                  $display("FAIL start_grant: grant_valid=%0b at tx_start, required 1", grant_valid);
               end
               mon_q.push_back({grant_id, tx_data});
               tx_cnt = TXLAT;
            end
         end
         prev_start = tx_start;
      end
   end

   initial begin : wdog
      #900000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      #2 resetn = 1'b0;
      #1;
      n_cmp++; if (state !== E_IDLE) begin n_bad++; $display("FAIL rst_state: got %0d, required 0", state); end
      n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL rst_tx_start: got %0b, required 0", tx_start); end
      n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx_data: got %02h, required 00", tx_data); end
      n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL rst_grant_valid: got %0b, required 0", grant_valid); end
      n_cmp++; if (grant_id !== 3'd0) begin n_bad++; $display("FAIL rst_grant_id: got %0d, required 0", grant_id); end
      n_cmp++; if (byte_count !== 16'd0) begin n_bad++; $display("FAIL rst_byte_count: got %0d, required 0", byte_count); end
      n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL rst_req_ready: got %b, required 000", req_ready); end
      clear_tb();
      repeat (2) @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic test_single();
      tx_t e, m;
      bit  ok;
      int  c;
      clear_reqs();
      push_req(0, 8'h41, 1'b0);
      push_req(0, 8'h42, 1'b1);
      predict();
      c = 0;
      while (!req_valid[0] && c < 10) begin @(negedge clock); c++; end
      n_cmp++;
      if (req_ready !== 3'b000 || state !== E_IDLE) begin
         n_bad++; $display("FAIL single_idle: ready %b state %0d, required ready 000 state 0", req_ready, state);
      end
      @(negedge clock);
      n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL single_ready_lat: ready %b, required 001", req_ready); end
      @(negedge clock);
      n_cmp++;
      if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
         n_bad++; $display("FAIL single_start_lat: tx_start %0b data %02h, required 1 / 41", tx_start, tx_data);
      end
      wait_done(400, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout: burst did not finish, required idle"); end
      n_cmp++; if (mon_q.size() != exp_q.size()) begin n_bad++; $display("FAIL single_count: sent %0d, required %0d", mon_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && mon_q.size() > 0) begin
         e = exp_q.pop_front(); m = mon_q.pop_front();
         n_cmp++;
         if (m !== e) begin n_bad++; $display("FAIL single_byte: got id %0d data %02h, required id %0d data %02h", m.id, m.d, e.id, e.d); end
      end
      mon_q.delete(); exp_q.delete();
      n_cmp++; if (byte_count !== 16'd2) begin n_bad++; $display("FAIL single_byte_count: got %0d, required 2", byte_count); end
      n_cmp++; if (grant_valid !== 1'b0 || state !== E_IDLE) begin n_bad++; $display("FAIL single_end: grant_valid %0b state %0d, required 0 / 0", grant_valid, state); end
   endtask

   task automatic test_contention();
      tx_t e, m;
      bit  ok;
      int  i;
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         push_req(0, 8'hC0 + 8'(k), 1'b1);
         push_req(1, 8'hD0 + 8'(k), 1'b1);
      end
      predict();
      wait_done(800, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL cont_timeout: bytes not finished, required idle"); end
      n_cmp++; if (mon_q.size() != 6) begin n_bad++; $display("FAIL cont_count: sent %0d, required 6", mon_q.size()); end
      i = 0;
      while (exp_q.size() > 0 && mon_q.size() > 0) begin
         e = exp_q.pop_front(); m = mon_q.pop_front();
         n_cmp++;
         if (m !== e || m.id !== 3'(i % 2)) begin
            n_bad++; $display("FAIL cont_byte%0d: got id %0d data %02h, required id %0d data %02h", i, m.id, m.d, e.id, e.d);
         end
         i++;
      end
      mon_q.delete(); exp_q.delete();
      n_cmp++; if (byte_count !== m_bc) begin n_bad++; $display("FAIL cont_byte_count: got %0d, required %0d", byte_count, m_bc); end
   endtask

   task automatic test_burst_cap();
      tx_t e, m;
      bit  ok;
      int  i;
      apply_reset();
      for (int k = 0; k < 6; k++) push_req(0, 8'h10 + 8'(k), 1'b0);
      push_req(1, 8'h20, 1'b0);
      push_req(1, 8'h21, 1'b1);
      predict();
      wait_done(1000, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL cap_timeout: bytes not finished, required idle"); end
      n_cmp++; if (mon_q.size() != 8) begin n_bad++; $display("FAIL cap_count: sent %0d, required 8", mon_q.size()); end
      i = 0;
      while (exp_q.size() > 0 && mon_q.size() > 0) begin
         e = exp_q.pop_front(); m = mon_q.pop_front();
         n_cmp++;
         if (m !== e) begin n_bad++; $display("FAIL cap_byte%0d: got id %0d data %02h, required id %0d data %02h", i, m.id, m.d, e.id, e.d); end
         if (i == 4) begin
            n_cmp++;
            if (m.id !== 3'd1) begin n_bad++; $display("FAIL cap_rotate: 5th byte from id %0d, required 1", m.id); end
         end
         i++;
      end
      mon_q.delete(); exp_q.delete();
      n_cmp++; if (byte_count !== m_bc) begin n_bad++; $display("FAIL cap_byte_count: got %0d, required %0d", byte_count, m_bc); end
   endtask

   task automatic test_hold_timeout();
      tx_t e, m;
      bit  ok;
      int  c;
      apply_reset();
      push_req(0, 8'h55, 1'b0);
      push_req(1, 8'h66, 1'b1);
      predict();
      c = 0;
      while (state !== E_WAIT && c < 20) begin @(negedge clock); c++; end
      c = 0;
      while (state !== E_GRANT && c < 40) begin @(negedge clock); c++; end
      n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL hold_ignore: ready %b while owner idle, required 000", req_ready); end
      c = 0;
      while (state !== E_REL && c < 40) begin @(negedge clock); c++; end
      n_cmp++; if (c != HC) begin n_bad++; $display("FAIL hold_cycles: release after %0d cycles, required %0d", c, HC); end
      wait_done(400, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL hold_timeout: bytes not finished, required idle"); end
      n_cmp++; if (mon_q.size() != exp_q.size()) begin n_bad++; $display("FAIL hold_count: sent %0d, required %0d", mon_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && mon_q.size() > 0) begin
         e = exp_q.pop_front(); m = mon_q.pop_front();
         n_cmp++;
         if (m !== e) begin n_bad++; $display("FAIL hold_byte: got id %0d data %02h, required id %0d data %02h", m.id, m.d, e.id, e.d); end
      end
      mon_q.delete(); exp_q.delete();
      n_cmp++; if (grant_id !== 3'd1) begin n_bad++; $display("FAIL hold_next_grant: grant_id %0d, required 1", grant_id); end
   endtask

   task automatic test_reset_mid();
      logic [2:0] tgt;
      int c;
      for (int ph = 0; ph < 2; ph++) begin
         tgt = (ph == 0) ? E_START : E_WAIT;
         clear_reqs();
         push_req(0, 8'h77, 1'b1);
         c = 0;
         while (state !== tgt && c < 20) begin @(negedge clock); c++; end
         #2 resetn = 1'b0;
         #1;
         n_cmp++;
         if (state !== E_IDLE || tx_start !== 1'b0 || byte_count !== 16'd0 || grant_valid !== 1'b0) begin
            n_bad++; $display("FAIL midrst_%0d: state %0d tx_start %0b byte_count %0d grant_valid %0b, required all 0", ph, state, tx_start, byte_count, grant_valid);
         end
         clear_tb();
         repeat (2) @(negedge clock);
         resetn = 1'b1;
      end
      @(negedge clock);
      inject = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         n_cmp++;
         if (state !== E_IDLE || tx_start !== 1'b0) begin
            n_bad++; $display("FAIL stray_done: state %0d tx_start %0b, required 0 / 0", state, tx_start);
         end
      end
      n_cmp++; if (mon_q.size() != 0) begin n_bad++; $display("FAIL stray_pulse: %0d starts seen, required 0", mon_q.size()); end
   endtask

   task automatic test_wrap();
      tx_t e, m;
      bit  ok;
      @(negedge clock);
      force dut.r_byte_count = 16'hFFFF;
      @(negedge clock);
      release dut.r_byte_count;
      m_bc = 16'hFFFF;
      clear_reqs();
      push_req(0, 8'hA5, 1'b1);
      predict();
      wait_done(400, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_timeout: byte not finished, required idle"); end
      while (exp_q.size() > 0 && mon_q.size() > 0) begin
         e = exp_q.pop_front(); m = mon_q.pop_front();
         n_cmp++;
         if (m !== e) begin n_bad++; $display("FAIL wrap_byte: got id %0d data %02h, required id %0d data %02h", m.id, m.d, e.id, e.d); end
      end
      mon_q.delete(); exp_q.delete();
      n_cmp++; if (byte_count !== 16'd0) begin n_bad++; $display("FAIL wrap_count: got %0d, required 0", byte_count); end
   endtask

   task automatic test_random();
      tx_t e, m;
      bit  ok;
      int  len;
      for (int rnd = 0; rnd < 6; rnd++) begin
         clear_reqs();
         for (int r = 0; r < NR; r++) begin
            len = int'($urandom_range(0, 6));
            for (int j = 0; j < len; j++) push_req(r, 8'($urandom), ($urandom_range(0, 3) == 0));
         end
         predict();
         wait_done(4000, ok);
         n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand%0d_timeout: bytes not finished, required idle", rnd); end
         n_cmp++; if (mon_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand%0d_count: sent %0d, required %0d", rnd, mon_q.size(), exp_q.size()); end
         while (exp_q.size() > 0 && mon_q.size() > 0) begin
            e = exp_q.pop_front(); m = mon_q.pop_front();
            n_cmp++;
            if (m !== e) begin n_bad++; $display("FAIL rand%0d_byte: got id %0d data %02h, required id %0d data %02h", rnd, m.id, m.d, e.id, e.d); end
         end
         mon_q.delete(); exp_q.delete();
         n_cmp++; if (byte_count !== m_bc) begin n_bad++; $display("FAIL rand%0d_byte_count: got %0d, required %0d", rnd, byte_count, m_bc); end
      end
   endtask

   initial begin : main
      clear_reqs();
      test_reset();
      test_single();
      test_contention();
      test_burst_cap();
      test_hold_timeout();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
